rr_stream_mux: RTL and testbench
================================

RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 The module SHALL have parameter NUM_IN, default 4, giving the number of input streams (range 2..32).
REQ-002 The module SHALL have parameter DATA_W, default 32, giving the payload width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_b, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, NUM_IN bits: per-stream valid.
REQ-006 The module SHALL have port in_data, input, NUM_IN*DATA_W bits: stream i's payload at bits [i*DATA_W +: DATA_W].
REQ-007 The module SHALL have port in_ready, output, NUM_IN bits: per-stream accept.
REQ-008 The module SHALL have port out_valid, output, 1 bit: the output register holds a beat.
REQ-009 The module SHALL have port out_data, output, DATA_W bits: the registered payload.
REQ-010 The module SHALL have port out_src, output, $clog2(NUM_IN) bits: the index of the stream that supplied out_data.
REQ-011 The module SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-012 The module SHALL instantiate the team's one-hot rotating-priority arbiter with WIDTH=NUM_IN, req=in_valid, and base=base_q, and SHALL use its one-hot grant unmodified.
REQ-013 base_q SHALL be a NUM_IN-bit one-hot register; the one-hot invariant SHALL hold in every cycle.
REQ-014 load_en SHALL equal (~out_valid | out_ready), giving a single output stage with full throughput: one beat per cycle when both sides stream.
REQ-015 in_ready[i] SHALL equal load_en & grant[i]; at most one in_ready bit SHALL be high per cycle, and in_ready SHALL never depend combinationally on in_data.
REQ-016 A transfer on stream i SHALL occur when in_valid[i] & in_ready[i] are both high.
REQ-017 On a transfer, at the next edge: out_data SHALL load in_data of stream i, out_src SHALL load i, and out_valid SHALL be 1.
REQ-018 On a transfer, base_q SHALL load grant rotated left by one with wrap: bit NUM_IN-1 goes to bit 0.
REQ-019 When load_en=1 and in_valid=0, out_valid SHALL go to 0, and out_data, out_src, and base_q SHALL hold.
REQ-020 When out_valid=1 and out_ready=0 (stall), out_valid, out_data, out_src, and base_q SHALL hold, and in_ready SHALL be all-zero.
REQ-021 Latency SHALL be exactly one cycle from an input transfer to the beat appearing on out_*.
REQ-022 Simultaneous output drain and new transfer in the same cycle SHALL replace the beat with no bubble.
REQ-023 Fairness: with all streams continuously valid and out_ready=1, grants SHALL cycle 0,1,...,NUM_IN-1,0,... and no stream SHALL wait more than NUM_IN-1 transfers.
REQ-024 The payload register SHALL load only on a transfer; no X SHALL propagate to out_data from non-granted streams.
REQ-025 Input-side protocol: the module SHALL tolerate in_valid deassertion before acceptance without a spurious transfer; a sender's data is captured only in a transfer cycle.

Reset
REQ-026 While rst_b=0, regardless of clk, the outputs SHALL be: out_valid=0, out_data=0, out_src=0, base_q=1 (stream 0 highest priority), in_ready=0.
REQ-027 Reset asserted mid-stall SHALL discard the held beat with no transfer reported.
REQ-028 After rst_b deasserts, the first transfer SHALL be permitted at the first rising edge at which rst_b is high.

Verification
REQ-029 NUM_IN=4, reset released, in_valid=4'b1111, out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, and out_valid stays 1.
REQ-030 base_q=4'b0100, in_valid=4'b0011 -> in_ready=4'b0001, next out_src=0, next base_q=4'b0010.
REQ-031 Stream 3 holds data 0xA5A5A5A5 and out_ready=0 for 5 cycles -> out_data stays 0xA5A5A5A5 and in_ready=0 throughout; when out_ready rises -> the next beat arrives 1 cycle later with no gap.
REQ-032 in_valid=0 while out_valid=1 and out_ready=1 -> out_valid=0 next cycle, and out_data and base_q unchanged.
REQ-033 rst_b pulsed low during a stall, asynchronously between edges -> out_valid=0 immediately and base_q=4'b0001; after release, in_valid=4'b1000 -> out_src=3.
REQ-034 Randomized valid/ready on all streams for 10k cycles -> scoreboard shows per-stream order preserved, no loss or duplication, and at most one in_ready bit per cycle.

Source files
------------

// File: rtl/rr_stream_mux.sv
// Round-robin N:1 stream multiplexer with a single registered output stage.
// A one-hot rotating-priority arbiter selects one valid input per accepted beat.

module rr_onehot_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] grant
);

    logic [2*WIDTH-1:0] dreq_s;
    logic [2*WIDTH-1:0] dgnt_s;

    // Doubled request vector: subtracting base finds the first request at or above base, with wrap
    always_comb begin
        dreq_s = {req, req};
        dgnt_s = dreq_s & ~(dreq_s - {{WIDTH{1'b0}}, base});
        grant  = dgnt_s[WIDTH-1:0] | dgnt_s[2*WIDTH-1:WIDTH];
    end

endmodule

module rr_stream_mux #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic [NUM_IN-1:0]          in_valid,
    input  logic [NUM_IN*DATA_W-1:0]   in_data,
    output logic [NUM_IN-1:0]          in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_IN)-1:0]  out_src,
    input  logic                       out_ready
);

    localparam int SRC_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0] base_q;
    logic [NUM_IN-1:0] grant_s;
    logic              load_en_s;
    logic              xfer_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [SRC_W-1:0]  sel_src_s;

    rr_onehot_arbiter #(
        .WIDTH (NUM_IN)
    ) u_arb (
        .req   (in_valid),
        .base  (base_q),
        .grant (grant_s)
    );

    // Handshake: ready is gated by reset so nothing is offered while rst_b is low
    always_comb begin
        load_en_s = ~out_valid | out_ready;
        in_ready  = {NUM_IN{rst_b & load_en_s}} & grant_s;
        xfer_s    = |(in_valid & in_ready);
    end

    // AND-OR mux on the one-hot grant keeps non-granted lanes (even X) out of the payload
    always_comb begin
        sel_data_s = {DATA_W{1'b0}};
        sel_src_s  = {SRC_W{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            sel_data_s = sel_data_s | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
            sel_src_s  = sel_src_s  | (SRC_W'(i) & {SRC_W{grant_s[i]}});
        end
    end

    // Output stage and rotating priority pointer
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_src   <= {SRC_W{1'b0}};
            base_q    <= {{(NUM_IN-1){1'b0}}, 1'b1};
        end else if (load_en_s) begin
            out_valid <= xfer_s;
            if (xfer_s) begin
                out_data <= sel_data_s;
                out_src  <= sel_src_s;
                base_q   <= {grant_s[NUM_IN-2:0], grant_s[NUM_IN-1]};
            end else begin
                out_data <= out_data;
                out_src  <= out_src;
                base_q   <= base_q;
            end
        end else begin
            out_valid <= out_valid;
            out_data  <= out_data;
            out_src   <= out_src;
            base_q    <= base_q;
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed vector table, stall/reset
// sequences, then randomized traffic against a behavioural round-robin model.

module tb_rr_stream_mux;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_b;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_ready;

    int n_chk  = 0;
    int n_pass = 0;

    rr_stream_mux #(.NUM_IN(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] iv;
        logic         ordy;
        logic [N-1:0] ir;
        logic         ov;
        logic [1:0]   src;
    } vec_t;

    vec_t tbl [16];

    // behavioural model state for the random phase
    int          prio;
    logic        m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          sent_cnt [N];
    int          recv_cnt [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] lane_data(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic set_lane_defaults();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = lane_data(i);
    endtask

    // One random-phase cycle: drive, predict, compare
    task automatic rand_cycle(input bit drive_en, input int cyc);
        logic [N-1:0] exp_ir;
        int           win;
        bit           le;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = drive_en && ($urandom_range(0, 99) < 60);
            in_data[i*DW +: DW] = in_valid[i] ? {8'(i), 24'(sent_cnt[i])} : $urandom;
        end
        out_ready = !drive_en || ($urandom_range(0, 99) < 70);
        #1;
        le  = !m_valid || out_ready;
        win = -1;
        if (le) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && in_valid[(prio + k) % N]) win = (prio + k) % N;
            end
        end
        exp_ir = (win >= 0) ? N'(1 << win) : '0;
        chk($sformatf("rnd%0d_in_ready", cyc), in_ready, exp_ir);
        if (out_valid && out_ready) begin
            chk($sformatf("rnd%0d_order", cyc), out_data, {8'(out_src), 24'(recv_cnt[out_src])});
            recv_cnt[out_src]++;
        end
        if (le) begin
            if (win >= 0) begin
                m_valid = 1'b1;
                m_data  = {8'(win), 24'(sent_cnt[win])};
                m_src   = win;
                prio    = (win + 1) % N;
                sent_cnt[win]++;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk($sformatf("rnd%0d_out_valid", cyc), out_valid, m_valid);
        if (m_valid) begin
            chk($sformatf("rnd%0d_out_data", cyc), out_data, m_data);
            chk($sformatf("rnd%0d_out_src", cyc), out_src, m_src);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[6]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[8]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[11] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};
        tbl[15] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};

        // reset state, with requests already pending
        rst_b     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_lane_defaults();
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_src", out_src, 2'd0);
        chk("rst_in_ready", in_ready, 4'b0000);
        chk("rst_base_q", dut.base_q, 4'b0001);
        @(negedge clk);
        rst_b = 1'b1;

        for (int r = 0; r < 16; r++) begin
            in_valid  = tbl[r].iv;
            out_ready = tbl[r].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].ir);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].ov);
            chk($sformatf("tbl%0d_out_src", r), out_src, tbl[r].src);
            chk($sformatf("tbl%0d_out_data", r), out_data, lane_data(int'(tbl[r].src)));
        end

        // long stall holding a beat from stream 3
        in_data[3*DW +: DW] = 32'hA5A5_A5A5;
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        #1;
        chk("s3_in_ready", in_ready, 4'b1000);
        @(posedge clk); #1;
        chk("s3_out_data", out_data, 32'hA5A5_A5A5);
        chk("s3_out_src", out_src, 2'd3);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", c), in_ready, 4'b0000);
            @(posedge clk); #1;
            chk($sformatf("stall%0d_out_valid", c), out_valid, 1'b1);
            chk($sformatf("stall%0d_out_data", c), out_data, 32'hA5A5_A5A5);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", in_ready, 4'b0001);
        @(posedge clk); #1;
        chk("unstall_out_valid", out_valid, 1'b1);
        chk("unstall_out_src", out_src, 2'd0);
        chk("unstall_out_data", out_data, lane_data(0));

        // asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 4'b0000);
        chk("arst_base_q", dut.base_q, 4'b0001);
        chk("arst_out_data", out_data, 32'h0);
        @(negedge clk);
        rst_b     = 1'b1;
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 4'b1000);
        @(posedge clk); #1;
        chk("post_rst_out_valid", out_valid, 1'b1);
        chk("post_rst_out_src", out_src, 2'd3);

        // randomized traffic from a fresh reset
        rst_b    = 1'b0;
        in_valid = '0;
        #3;
        @(negedge clk);
        rst_b   = 1'b1;
        prio    = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        for (int i = 0; i < N; i++) begin
            sent_cnt[i] = 0;
            recv_cnt[i] = 0;
        end
        for (int c = 0; c < 10000; c++) rand_cycle(1'b1, c);
        for (int c = 0; c < 3; c++) rand_cycle(1'b0, 10000 + c);
        for (int i = 0; i < N; i++)
            chk($sformatf("stream%0d_count", i), recv_cnt[i], sent_cnt[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
